// File: rtl/bcd_time_if.sv
// Time-keeper bundle: SET-mode controls in, six BCD digits plus pm/sec_tick out.
// Latency: n/a (signal bundle only).
// Backpressure: none; the outputs are levels and pulses, never stalled.
// Ports: set_mode, inc_min, inc_hour (controls); right/left_sec, right/left_min,
//        right/left_hour (BCD digits), pm, sec_tick (status).
interface bcd_time_if;
    logic       set_mode;
    logic       inc_min;
    logic       inc_hour;
    logic [3:0] right_sec;
    logic [3:0] left_sec;
    logic [3:0] right_min;
    logic [3:0] left_min;
    logic [3:0] right_hour;
    logic [3:0] left_hour;
    logic       pm;
    logic       sec_tick;

    // master: the block that drives the controls and observes the time
    modport master (
        output set_mode, inc_min, inc_hour,
        input  right_sec, left_sec, right_min, left_min, right_hour, left_hour, pm, sec_tick
    );

    // slave: the time keeper itself
    modport slave (
        input  set_mode, inc_min, inc_hour,
        output right_sec, left_sec, right_min, left_min, right_hour, left_hour, pm, sec_tick
    );
endinterface

// File: rtl/bcd_time_keeper.sv
// BCD time-of-day core (hh:mm:ss) with a 1 Hz prescaler and a SET mode for button stepping.
// Latency: every output is registered; digits change one cycle after the enabling edge.
// Backpressure: none; controls are sampled every cycle and the time always advances in RUN.
// Ports: clk, rst (sync, active-high); bus (bcd_time_if.slave) carries set_mode,
//        inc_min, inc_hour in and the six BCD digits, pm and sec_tick out.
module bcd_time_keeper #(
    parameter int CLK_FREQ = 100_000_000,
    parameter bit MODE_24H = 1'b1
) (
    input  logic        clk,
    input  logic        rst,
    bcd_time_if.slave   bus
);

    localparam int PW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(CLK_FREQ - 1);

    typedef enum logic {RUN = 1'b0, SET = 1'b1} state_t;

    state_t        state, state_nxt;
    logic [PW-1:0] presc;
    logic          min_prev, hour_prev;

    logic          tick, enter_set, min_step, hour_step;
    logic          sec_wrap, min_inc, hour_inc;
    logic [7:0]    sec_nxt, min_nxt;
    logic [8:0]    hour_nxt;

    // mm or ss + 1 in BCD; returns {tens, units}, 59 wraps to 00
    function automatic logic [7:0] inc_base60(input logic [3:0] tens, input logic [3:0] units);
        logic [7:0] res;
        res = {tens, units + 4'd1};
        if (units == 4'd9) begin
            res = (tens == 4'd5) ? 8'h00 : {tens + 4'd1, 4'd0};
        end
        return res;
    endfunction

    // hh + 1 in BCD; returns {pm_toggle, tens, units}
    function automatic logic [8:0] inc_hour_bcd(input logic [3:0] tens, input logic [3:0] units);
        logic [8:0] res;
        res = {1'b0, tens, units + 4'd1};
        if (units == 4'd9) begin
            res = {1'b0, tens + 4'd1, 4'd0};
        end
        if (MODE_24H) begin
            if (tens == 4'd2 && units == 4'd3) res = 9'h000;
        end else begin
            // 12h dial runs 12,01..11; the meridiem flips when 11 rolls to 12
            if (tens == 4'd1 && units == 4'd1) res = {1'b1, 4'd1, 4'd2};
            if (tens == 4'd1 && units == 4'd2) res = {1'b0, 4'd0, 4'd1};
        end
        return res;
    endfunction

    always_comb begin
        state_nxt = state;
        case (state)
            RUN: if (bus.set_mode)  state_nxt = SET;
            SET: if (!bus.set_mode) state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // A tick pending in the same cycle set_mode rises is dropped: SET wins.
    assign tick      = (state == RUN) && !bus.set_mode && (presc == PRESC_LAST);
    assign enter_set = (state == RUN) && bus.set_mode;
    assign min_step  = (state == SET) && bus.inc_min  && !min_prev;
    assign hour_step = (state == SET) && bus.inc_hour && !hour_prev;

    // Carry chain resolves in one cycle; a button step on minutes never carries into hours.
    assign sec_wrap  = tick && (bus.left_sec == 4'd5) && (bus.right_sec == 4'd9);
    assign min_inc   = sec_wrap || min_step;
    assign hour_inc  = (sec_wrap && bus.left_min == 4'd5 && bus.right_min == 4'd9) || hour_step;

    assign sec_nxt   = inc_base60(bus.left_sec, bus.right_sec);
    assign min_nxt   = inc_base60(bus.left_min, bus.right_min);
    assign hour_nxt  = inc_hour_bcd(bus.left_hour, bus.right_hour);

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= RUN;
            presc          <= '0;
            min_prev       <= 1'b0;
            hour_prev      <= 1'b0;
            bus.sec_tick   <= 1'b0;
            bus.right_sec  <= 4'd0;
            bus.left_sec   <= 4'd0;
            bus.right_min  <= 4'd0;
            bus.left_min   <= 4'd0;
            bus.right_hour <= MODE_24H ? 4'd0 : 4'd2;
            bus.left_hour  <= MODE_24H ? 4'd0 : 4'd1;
            bus.pm         <= 1'b0;
        end else begin
            state     <= state_nxt;
            // edge registers track in RUN too, so a button held while entering SET is not a step
            min_prev  <= bus.inc_min;
            hour_prev <= bus.inc_hour;
            bus.sec_tick <= tick;

            if ((state == RUN) && !bus.set_mode && !tick) presc <= presc + PW'(1);
            else                                         presc <= '0;

            if (enter_set) begin
                bus.left_sec  <= 4'd0;
                bus.right_sec <= 4'd0;
            end else if (tick) begin
                {bus.left_sec, bus.right_sec} <= sec_nxt;
            end

            if (min_inc) {bus.left_min, bus.right_min} <= min_nxt;

            if (hour_inc) begin
                {bus.left_hour, bus.right_hour} <= hour_nxt[7:0];
                bus.pm <= MODE_24H ? 1'b0 : (bus.pm ^ hour_nxt[8]);
            end
        end
    end

endmodule
